// File: rtl/processor_pkg.sv
// Shared types for the 8-bit accumulator processor: opcodes, FSM states,
// ALU operations and the instruction-length decode helper.
package processor_pkg;

   typedef enum logic [3:0] {
      OP_NOP = 4'h0, OP_LDA = 4'h1, OP_STA = 4'h2, OP_ADD = 4'h3,
      OP_SUB = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7,
      OP_NOT = 4'h8, OP_LDI = 4'h9, OP_JMP = 4'hA, OP_JZ  = 4'hB,
      OP_JC  = 4'hC, OP_SHL = 4'hD, OP_SHR = 4'hE, OP_HLT = 4'hF
   } opcode_e;

   typedef enum logic [1:0] {
      S_FETCH, S_OPERAND, S_EXEC, S_HALT
   } state_e;

   typedef enum logic [3:0] {
      ALU_PASS, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
      ALU_XOR, ALU_NOT, ALU_SHL, ALU_SHR
   } alu_op_e;

   // One bit per opcode: set for the single-byte ops NOP, NOT, SHL, SHR, HLT.
   localparam logic [15:0] ONE_BYTE_OPS = 16'b1110_0001_0000_0001;

   // Illegal encodings are treated as single-byte so they trap without an operand fetch.
   function automatic logic needs_operand(input logic [7:0] ir);
      return (ir[3:0] == 4'h0) && !ONE_BYTE_OPS[ir[7:4]];
   endfunction

endpackage

// File: rtl/processor_alu.sv
// Combinational ALU: a is the accumulator, b the memory byte or immediate.
module processor_alu
   import processor_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  alu_op_e    op,
   output logic [7:0] result,
   output logic       carry_out,
   output logic       zero
);

   logic [8:0] w_sum;

   always_comb begin
      w_sum     = 9'd0;
      result    = b;
      carry_out = 1'b0;
      case (op)
         ALU_ADD: begin
            w_sum     = {1'b0, a} + {1'b0, b};
            result    = w_sum[7:0];
            carry_out = w_sum[8];
         end
         ALU_SUB: begin
            // bit 8 of the widened difference is the borrow
            w_sum     = {1'b0, a} - {1'b0, b};
            result    = w_sum[7:0];
            carry_out = w_sum[8];
         end
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_XOR: result = a ^ b;
         ALU_NOT: result = ~a;
         ALU_SHL: begin
            result    = {a[6:0], 1'b0};
            carry_out = a[7];
         end
         ALU_SHR: begin
            result    = {1'b0, a[7:1]};
            carry_out = a[0];
         end
         default: result = b;
      endcase
   end

   assign zero = (result == 8'd0);

endmodule

// File: rtl/processor.sv
// Multi-cycle accumulator processor: FETCH -> [OPERAND] -> EXEC, HALT on HLT or
// illegal encoding. Program and data share one external combinational-read memory.
module processor
   import processor_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] Mem_IN,
   input  logic [7:0] Mem_OUT,
   output logic [7:0] Mem_ADDR,
   output logic       write,
   output logic       zero,
   output logic       carry,
   output logic       error
);

   state_e     r_state, w_next;
   logic [7:0] r_pc, r_ir, r_opr, r_acc;
   logic       r_z, r_c, r_err;

   opcode_e    w_op;
   logic       w_illegal;
   alu_op_e    w_alu_op;
   logic       w_acc_we, w_c_we, w_pc_ld;
   logic [7:0] w_alu_b, w_alu_res;
   logic       w_alu_c, w_alu_z;

   assign w_op      = opcode_e'(r_ir[7:4]);
   assign w_illegal = (r_ir[3:0] != 4'h0);
   assign w_alu_b   = (w_op == OP_LDI) ? r_opr : Mem_OUT;

   always_comb begin
      w_alu_op = ALU_PASS;
      w_acc_we = 1'b0;
      w_c_we   = 1'b0;
      w_pc_ld  = 1'b0;
      case (w_op)
         OP_LDA, OP_LDI: w_acc_we = 1'b1;
         OP_ADD: begin w_alu_op = ALU_ADD; w_acc_we = 1'b1; w_c_we = 1'b1; end
         OP_SUB: begin w_alu_op = ALU_SUB; w_acc_we = 1'b1; w_c_we = 1'b1; end
         OP_AND: begin w_alu_op = ALU_AND; w_acc_we = 1'b1; end
         OP_OR:  begin w_alu_op = ALU_OR;  w_acc_we = 1'b1; end
         OP_XOR: begin w_alu_op = ALU_XOR; w_acc_we = 1'b1; end
         OP_NOT: begin w_alu_op = ALU_NOT; w_acc_we = 1'b1; end
         OP_SHL: begin w_alu_op = ALU_SHL; w_acc_we = 1'b1; w_c_we = 1'b1; end
         OP_SHR: begin w_alu_op = ALU_SHR; w_acc_we = 1'b1; w_c_we = 1'b1; end
         OP_JMP: w_pc_ld = 1'b1;
         OP_JZ:  w_pc_ld = r_z;
         OP_JC:  w_pc_ld = r_c;
         default: ;
      endcase
   end

   processor_alu u_alu (
      .a         (r_acc),
      .b         (w_alu_b),
      .op        (w_alu_op),
      .result    (w_alu_res),
      .carry_out (w_alu_c),
      .zero      (w_alu_z)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_FETCH;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      Mem_ADDR = r_pc;
      write    = 1'b0;
      case (r_state)
         S_FETCH:   w_next = needs_operand(Mem_OUT) ? S_OPERAND : S_EXEC;
         S_OPERAND: w_next = S_EXEC;
         S_EXEC: begin
            Mem_ADDR = r_opr;
            if (w_illegal || w_op == OP_HLT) begin
               w_next = S_HALT;
            end else begin
               w_next = S_FETCH;
               write  = (w_op == OP_STA);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc  <= 8'd0;
         r_ir  <= 8'd0;
         r_opr <= 8'd0;
         r_acc <= 8'd0;
         r_z   <= 1'b0;
         r_c   <= 1'b0;
         r_err <= 1'b0;
      end else begin
         case (r_state)
            S_FETCH: begin
               r_ir <= Mem_OUT;
               r_pc <= r_pc + 8'd1;
            end
            S_OPERAND: begin
               r_opr <= Mem_OUT;
               r_pc  <= r_pc + 8'd1;
            end
            S_EXEC: begin
               if (w_illegal) begin
                  r_err <= 1'b1;
               end else begin
                  if (w_acc_we) begin
                     r_acc <= w_alu_res;
                     r_z   <= w_alu_z;
                  end
                  if (w_c_we)  r_c  <= w_alu_c;
                  if (w_pc_ld) r_pc <= r_opr;
               end
            end
            default: ;
         endcase
      end
   end

   assign Mem_IN = r_acc;
   assign zero   = r_z;
   assign carry  = r_c;
   assign error  = r_err;

endmodule

// File: tb/tb_processor.sv
// Directed and random-program bench for the accumulator processor, checked against
// an instruction-level interpreter with cycle costs taken from the instruction lengths.
module tb_processor;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] Mem_IN, Mem_OUT, Mem_ADDR;
   logic       write, zero, carry, error;

   logic [7:0] mem [256];
   logic [7:0] img [256];
   logic       load = 1'b0;
   int         wr_cnt = 0;
   logic [7:0] wr_a = 8'd0, wr_d = 8'd0;

   int n_err = 0;
   int n_chk = 0;

   logic [7:0] m_mem [256];
   int         m_pc, m_acc, m_cyc, m_sta;
   bit         m_z, m_c, m_err;
   logic [7:0] loop_seq [7];

   processor dut (
      .clk(clk), .reset(reset), .Mem_IN(Mem_IN), .Mem_OUT(Mem_OUT),
      .Mem_ADDR(Mem_ADDR), .write(write), .zero(zero), .carry(carry), .error(error)
   );

   always #5 clk = ~clk;

   assign Mem_OUT = mem[Mem_ADDR];

   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < 256; i++) mem[i] <= img[i];
      end else if (write) begin
         mem[Mem_ADDR] <= Mem_IN;
         wr_cnt <= wr_cnt + 1;
         wr_a   <= Mem_ADDR;
         wr_d   <= Mem_IN;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_img();
      for (int i = 0; i < 256; i++) img[i] = 8'h00;
   endtask

   // Load the image while held in reset, then release just after an edge.
   task automatic start();
      reset = 1'b0;
      load  = 1'b1;
      step(1);
      load  = 1'b0;
      step(1);
      reset = 1'b1;
   endtask

   function automatic bit is_two_byte(input int op);
      return op inside {[1:7], [9:12]};
   endfunction

   // Instruction-level reference: one fetch cycle, one operand cycle for two-byte
   // ops, one execute cycle; illegal bytes trap after fetch + execute.
   task automatic model_run(output bit halted);
      int pc, acc, opr, cyc, op, mv, s;
      bit z, c;
      logic [7:0] ir;
      for (int i = 0; i < 256; i++) m_mem[i] = img[i];
      pc = 0; acc = 0; opr = 0; z = 0; c = 0; cyc = 0;
      m_err = 0; m_sta = 0; halted = 0;
      while (!halted && cyc < 400) begin
         ir = m_mem[pc];
         pc = (pc + 1) % 256;
         cyc++;
         op = int'(ir[7:4]);
         if (ir[3:0] != 4'h0) begin
            m_err = 1; halted = 1; cyc++;
         end else begin
            if (is_two_byte(op)) begin
               opr = int'(m_mem[pc]);
               pc = (pc + 1) % 256;
               cyc++;
            end
            cyc++;
            mv = int'(m_mem[opr]);
            case (op)
               1:  acc = mv;
               2:  begin m_mem[opr] = 8'(acc); m_sta++; end
               3:  begin s = acc + mv; c = (s > 255); acc = s % 256; end
               4:  begin c = (acc < mv); acc = (acc - mv + 256) % 256; end
               5:  acc = acc & mv;
               6:  acc = acc | mv;
               7:  acc = acc ^ mv;
               8:  acc = 255 - acc;
               9:  acc = opr;
               10: pc = opr;
               11: if (z) pc = opr;
               12: if (c) pc = opr;
               13: begin c = (acc >= 128); acc = (acc * 2) % 256; end
               14: begin c = (acc % 2 == 1); acc = acc / 2; end
               15: halted = 1;
               default: ;
            endcase
            if (op inside {[1:1], [3:9], 13, 14}) z = (acc == 0);
         end
      end
      m_pc = pc; m_acc = acc; m_z = z; m_c = c; m_cyc = cyc;
   endtask

   task automatic gen_prog();
      int a, r, op;
      for (int i = 0; i < 256; i++) img[i] = (i >= 128) ? 8'($urandom) : 8'hF0;
      a = 0;
      while (a < 'h70) begin
         r = $urandom_range(0, 39);
         if (r == 0) begin
            img[a] = {4'($urandom_range(0, 15)), 4'($urandom_range(1, 15))};
            a++;
         end else begin
            op = $urandom_range(0, 14);
            img[a] = {4'(op), 4'h0};
            a++;
            if (is_two_byte(op)) begin
               if (op == 9)       img[a] = 8'($urandom);
               else if (op >= 10) img[a] = 8'($urandom_range(0, 'h7F));
               else               img[a] = 8'($urandom_range('h80, 'hFF));
               a++;
            end
         end
      end
   endtask

   initial begin
      int base, bad;
      bit halted;
      loop_seq[0] = 8'h00; loop_seq[1] = 8'h00; loop_seq[2] = 8'h01; loop_seq[3] = 8'h00;
      loop_seq[4] = 8'h02; loop_seq[5] = 8'h03; loop_seq[6] = 8'h00;

      // Reset held 5 cycles
      clear_img();
      img[0] = 8'h10; img[1] = 8'h80; img[2] = 8'h30; img[3] = 8'h81;
      img[4] = 8'h20; img[5] = 8'h82; img[6] = 8'hF0;
      img['h80] = 8'h0F; img['h81] = 8'h01;
      #1;
      load = 1'b1; step(1); load = 1'b0;
      step(4);
      chk("rst_write", write, 0);
      chk("rst_addr", Mem_ADDR, 8'h00);
      chk("rst_min", Mem_IN, 8'h00);
      chk("rst_zero", zero, 0);
      chk("rst_carry", carry, 0);
      chk("rst_error", error, 0);
      reset = 1'b1;
      chk("first_fetch_addr", Mem_ADDR, 8'h00);

      // Load/add/store
      base = wr_cnt;
      step(11);
      chk("las_wr_count", wr_cnt - base, 1);
      chk("las_wr_addr", wr_a, 8'h82);
      chk("las_wr_data", wr_d, 8'h10);
      chk("las_mem82", mem['h82], 8'h10);
      chk("las_zero", zero, 0);
      chk("las_carry", carry, 0);
      chk("las_halt_addr", Mem_ADDR, 8'h07);
      step(3);
      chk("las_halt_hold", Mem_ADDR, 8'h07);
      chk("las_halt_wr", write, 0);

      // Flags
      clear_img();
      img[0] = 8'h90; img[1] = 8'hFF; img[2] = 8'h30; img[3] = 8'h80;
      img[4] = 8'h90; img[5] = 8'h05; img[6] = 8'h40; img[7] = 8'h81;
      img[8] = 8'h50; img[9] = 8'h82; img[10] = 8'hF0;
      img['h80] = 8'h01; img['h81] = 8'h06; img['h82] = 8'h00;
      start();
      step(6);
      chk("add_acc", Mem_IN, 8'h00);
      chk("add_zero", zero, 1);
      chk("add_carry", carry, 1);
      step(6);
      chk("sub_acc", Mem_IN, 8'hFF);
      chk("sub_zero", zero, 0);
      chk("sub_carry", carry, 1);
      step(3);
      chk("and_zero", zero, 1);
      chk("and_carry", carry, 1);

      // Branches
      clear_img();
      img[0] = 8'h90; img[1] = 8'h01; img[2] = 8'hB0; img[3] = 8'h10;
      img[4] = 8'h90; img[5] = 8'h00; img[6] = 8'hB0; img[7] = 8'h20;
      img['h20] = 8'h90; img['h21] = 8'h80; img['h22] = 8'hD0;
      img['h23] = 8'hC0; img['h24] = 8'h30; img['h30] = 8'hF0;
      start();
      step(6);
      chk("jz_not_taken", Mem_ADDR, 8'h04);
      step(6);
      chk("jz_taken", Mem_ADDR, 8'h20);
      step(5);
      chk("shl_carry", carry, 1);
      chk("shl_zero", zero, 1);
      step(3);
      chk("jc_taken", Mem_ADDR, 8'h30);
      step(2);
      chk("br_halt", Mem_ADDR, 8'h31);

      // JMP 00 loop never halts
      clear_img();
      img[2] = 8'hA0; img[3] = 8'h00;
      start();
      for (int k = 0; k < 35; k++) begin
         chk($sformatf("loop_addr_%0d", k), Mem_ADDR, loop_seq[k % 7]);
         step(1);
      end
      chk("loop_no_error", error, 0);

      // Illegal opcode
      clear_img();
      img[0] = 8'h13;
      start();
      step(1);
      chk("ill_err_early", error, 0);
      step(1);
      chk("ill_err", error, 1);
      chk("ill_halt_addr", Mem_ADDR, 8'h01);
      chk("ill_write", write, 0);
      step(3);
      chk("ill_err_hold", error, 1);
      chk("ill_halt_hold", Mem_ADDR, 8'h01);
      reset = 1'b0;
      #1;
      chk("ill_err_cleared", error, 0);

      // Reset during STA execute
      clear_img();
      img[0] = 8'h90; img[1] = 8'hAA; img[2] = 8'h20; img[3] = 8'h90; img[4] = 8'hF0;
      img['h90] = 8'h55;
      start();
      step(5);
      chk("sta_write_hi", write, 1);
      chk("sta_addr", Mem_ADDR, 8'h90);
      #2;
      reset = 1'b0;
      #1;
      chk("sta_abort_write", write, 0);
      chk("sta_abort_addr", Mem_ADDR, 8'h00);
      step(1);
      chk("sta_abort_mem", mem['h90], 8'h55);
      reset = 1'b1;
      chk("sta_restart_addr", Mem_ADDR, 8'h00);
      step(8);
      chk("sta_rerun_mem", mem['h90], 8'hAA);
      chk("sta_rerun_halt", Mem_ADDR, 8'h05);

      // Random programs against the interpreter
      for (int t = 0; t < 20; t++) begin
         halted = 0;
         for (int tries = 0; tries < 50 && !halted; tries++) begin
            gen_prog();
            model_run(halted);
         end
         if (halted) begin
            start();
            base = wr_cnt;
            step(m_cyc);
            chk($sformatf("rnd%0d_error", t), error, 32'(m_err));
            chk($sformatf("rnd%0d_zero", t), zero, 32'(m_z));
            chk($sformatf("rnd%0d_carry", t), carry, 32'(m_c));
            chk($sformatf("rnd%0d_acc", t), Mem_IN, 32'(m_acc));
            chk($sformatf("rnd%0d_pc", t), Mem_ADDR, 32'(m_pc));
            chk($sformatf("rnd%0d_stores", t), wr_cnt - base, m_sta);
            bad = 0;
            for (int i = 0; i < 256; i++) if (mem[i] !== m_mem[i]) bad++;
            chk($sformatf("rnd%0d_mem_bad_bytes", t), bad, 0);
            step(3);
            chk($sformatf("rnd%0d_halt_hold", t), Mem_ADDR, 32'(m_pc));
            chk($sformatf("rnd%0d_halt_wr", t), write, 0);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
